// File: rtl/multiplier_seq.sv
// Signed fixed-point multiplier, out = in * constant >> FRAC_BITS, computed one bit per cycle
// on operand magnitudes, then rounded half away from zero and saturated on the result sign.
module multiplier_seq #(
  parameter int WIDTH     = 32,
  parameter int FRAC_BITS = 31
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [WIDTH-1:0] constant,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_sat,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [2*WIDTH:0] NEG_LIM = (2*WIDTH+1)'(1) << (WIDTH-1);
  localparam logic [2*WIDTH:0] POS_LIM = NEG_LIM - (2*WIDTH+1)'(1);
  localparam logic [WIDTH-1:0] MAX_VAL = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_FINAL,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mult_q, mult_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               sign_q, sign_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   out_data_q, out_data_d;
  logic               out_sat_q, out_sat_d;

  logic               accept;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [2*WIDTH-1:0] shifted;
  logic [2*WIDTH:0]   mag;
  logic [WIDTH-1:0]   mag_w;

  // Accept path doubles as the release path when DONE is retired on the same edge
  assign in_ready  = !clear && (state_q == S_IDLE || (state_q == S_DONE && out_ready));
  assign accept    = in_valid && in_ready;
  assign busy      = (state_q != S_IDLE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;

  always_comb begin
    abs_a   = in_data[WIDTH-1]  ? (~in_data + 1'b1)  : in_data;
    abs_b   = constant[WIDTH-1] ? (~constant + 1'b1) : constant;
    shifted = acc_q >> FRAC_BITS;
    mag     = {1'b0, shifted} + {{(2*WIDTH){1'b0}}, acc_q[FRAC_BITS-1]};
    mag_w   = mag[WIDTH-1:0];
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    mcand_d     = mcand_q;
    mult_d      = mult_q;
    cnt_d       = cnt_q;
    sign_d      = sign_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;

    case (state_q)
      S_BUSY: begin
        if (mult_q[0]) acc_d = acc_q + mcand_q;
        mcand_d = mcand_q << 1;
        mult_d  = mult_q >> 1;
        cnt_d   = cnt_q - 1'b1;
        if (cnt_q == '0) state_d = S_FINAL;
      end
      S_FINAL: begin
        if (!sign_q && mag > POS_LIM) begin
          out_data_d = MAX_VAL;
          out_sat_d  = 1'b1;
        end else if (sign_q && mag > NEG_LIM) begin
          out_data_d = MIN_VAL;
          out_sat_d  = 1'b1;
        end else begin
          out_data_d = sign_q ? (~mag_w + 1'b1) : mag_w;
          out_sat_d  = 1'b0;
        end
        out_valid_d = 1'b1;
        state_d     = S_DONE;
      end
      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: ;
    endcase

    if (accept) begin
      mcand_d = {{WIDTH{1'b0}}, abs_a};
      mult_d  = abs_b;
      acc_d   = '0;
      cnt_d   = CW'(WIDTH-1);
      sign_d  = in_data[WIDTH-1] ^ constant[WIDTH-1];
      state_d = S_BUSY;
    end

    if (clear) begin
      state_d     = S_IDLE;
      out_valid_d = 1'b0;
      out_sat_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      mcand_q     <= '0;
      mult_q      <= '0;
      cnt_q       <= '0;
      sign_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      mcand_q     <= mcand_d;
      mult_q      <= mult_d;
      cnt_q       <= cnt_d;
      sign_q      <= sign_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
    end
  end

endmodule
